id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
Pipeline stage register between decode (register-file read) and execute in the RV32 core. Captures decoded fields and the two register-file operands. Detects load-use hazards and inserts a one-cycle bubble, and holds while execute is busy. Keeps held operands coherent with writeback, and counts hazard bubbles for performance monitoring.

Parameters:
XLEN, 32, datapath width
ALU_OP_W, 4, width of ALU opcode field
CNT_W, 32, width of saturating bubble counter

Ports:
clk  in  1  core clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode slot holds a real instruction
id_pc  in  XLEN  PC of decode instruction
id_rs1, id_rs2  in  5  source register indices
id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2
id_rd  in  5  destination index
id_rd_wen  in  1  instruction writes rd
id_imm  in  XLEN  decoded immediate
id_alu_op  in  ALU_OP_W  ALU operation
id_is_load, id_is_store, id_is_branch  in  1  class flags
rf_data1, rf_data2  in  XLEN  register-file read data for id_rs1/id_rs2
wb_wr_en  in  1  writeback write enable (same signal driving register-file write)
wb_rd  in  5  writeback destination
wb_data  in  XLEN  writeback data
ex_ready  in  1  execute can accept a new instruction this cycle
flush  in  1  branch/jump redirect, kill decode and this stage
id_stall  out  1  combinational: hold IF/ID this cycle
ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rd_wen, ex_imm, ex_alu_op, ex_is_load, ex_is_store, ex_is_branch  out  same widths as id_*  registered stage contents
ex_op1, ex_op2  out  XLEN  registered operands
bubble_cnt  out  CNT_W  count of hazard bubbles inserted

Behaviour:
- Reset (rst_n low, any time, async): every output register 0, including ex_valid, flags, ex_op1/2 and bubble_cnt. id_stall is 0 while in reset.
- Hazard (combinational): id_valid & ex_valid & ex_is_load & ex_rd_wen & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- id_stall = ~flush & (hazard | ~ex_ready).
- Per-edge priority, highest first:
  1. flush: ex_valid, ex_rd_wen, ex_is_load, ex_is_store, ex_is_branch <= 0. Other fields are don't-care and hold. Applies even when ex_ready = 0.
  2. ~ex_ready (hold): all fields hold, except operand refresh (below).
  3. hazard (bubble): control fields cleared as for flush. bubble_cnt += 1, saturating at 2^CNT_W-1.
  4. Otherwise capture: all ex_* <= id_*, ex_valid <= id_valid.
- Capture operand: op1 = 0 if id_rs1 == 0; else wb_data if wb_wr_en & wb_rd == id_rs1; else rf_data1. op2 uses the same rule with rs2.
- Hold refresh: during a hold with ex_valid = 1, if wb_wr_en & wb_rd == ex_rs1 & ex_rs1 != 0, then ex_op1 <= wb_data. ex_op2 follows the same rule. Writes to x0 never alter operands.
- Latency: one cycle ID->EX. A load-use hazard costs exactly one bubble. Forwarding after the bubble is owned by the execute stage.
- bubble_cnt is never cleared except by reset. It does not increment on flush or hold cycles.

Decomposition:
- Shared package rv32_pkg holds XLEN, REG_ADDR_W = 5, ALU_OP_W, and the ALU opcode constants including ALU_NOP.
- One sub-module, id_ex_bypass: a combinational index/enable/data match mux implementing the x0/WB/register-file select. It is instanced four times: capture op1/op2 and refresh op1/op2.

Test Plan:
1. Assert rst_n low mid-stream with ex_valid = 1 and bubble_cnt = 3 -> all outputs 0 immediately, before any clock edge.
2. id_valid = 1, rs1 = 5/rf_data1 = 0x11, rs2 = 6/rf_data2 = 0x22, ex_ready = 1 -> next edge: ex_valid = 1, ex_op1 = 0x11, ex_op2 = 0x22. id_stall stays 0.
3. EX holds lw x7; ID holds add x8,x7,x1 -> id_stall = 1 that cycle. Next edge: ex_valid = 0, bubble_cnt = 1. Following edge: the add is captured with ex_rs1 = 7.
4. EX holds lw x0 and ID reads x0; separately, ID has id_use_rs2 = 0 with rs2 == ex_rd -> no stall, bubble_cnt unchanged.
5. ex_ready = 0 for 3 cycles with ex_rs1 = 5; WB writes x5 = 0xDEAD in cycle 2 -> ex_op1 = 0xDEAD after that edge, other fields unchanged, id_stall = 1 throughout.
6. flush = 1 together with hazard and ex_ready = 0 -> id_stall = 0, next edge ex_valid = 0, bubble_cnt unchanged. Separately, capture with wb_rd = rs1 = 9 and wb_data = 0x55 -> ex_op1 = 0x55 regardless of rf_data1.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 core definitions.
// Holds the datapath width, the register index width, the ALU opcode width
// and the ALU opcode encodings. ALU_NOP is the all-zero encoding, so a
// cleared pipeline register decodes as a no-op.
package rv32_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALU_OP_W   = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_NOP  = 4'h0,
        ALU_ADD  = 4'h1,
        ALU_SUB  = 4'h2,
        ALU_AND  = 4'h3,
        ALU_OR   = 4'h4,
        ALU_XOR  = 4'h5,
        ALU_SLL  = 4'h6,
        ALU_SRL  = 4'h7,
        ALU_SRA  = 4'h8,
        ALU_SLT  = 4'h9,
        ALU_SLTU = 4'hA,
        ALU_LUI  = 4'hB
    } alu_op_e;

endpackage

// File: rtl/id_ex_bypass.sv
// Operand select for a single register read port.
// Returns 0 for x0. Returns the writeback data when a writeback to the same
// (non-zero) register is happening this cycle. Otherwise returns base_data.
// Ports:
//   rd_idx    : register index being read
//   wr_en     : writeback write enable
//   wr_idx    : writeback destination index
//   wr_data   : writeback data
//   base_data : value to use when neither x0 nor a writeback match applies
//   data      : selected operand
module id_ex_bypass
    import rv32_pkg::*;
#(
    parameter int DATA_W = rv32_pkg::XLEN
) (
    input  logic [REG_ADDR_W-1:0] rd_idx,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_idx,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W-1:0]     base_data,
    output logic [DATA_W-1:0]     data
);

    logic is_x0;
    logic wb_hit;

    assign is_x0  = (rd_idx == '0);
    assign wb_hit = wr_en & (wr_idx == rd_idx);

    always_comb begin
        data = base_data;
        if (is_x0) begin
            data = '0;
        end else if (wb_hit) begin
            data = wr_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32 core.
// Captures the decoded fields and both register-file operands. Inserts a
// one-cycle bubble on a load-use hazard and holds while execute is busy.
// Held operands track writeback so they never go stale. Bubbles are counted
// in a saturating counter.
// Ports:
//   clk, rst_n         : clock, async active-low reset
//   id_*               : decoded instruction from the decode stage
//   rf_data1/2         : register-file read data for id_rs1/id_rs2
//   wb_wr_en/rd/data   : writeback port, the same one that writes the register file
//   ex_ready           : execute accepts a new instruction this cycle
//   flush              : redirect, kills the contents of this stage
//   id_stall           : hold IF/ID this cycle (combinational)
//   ex_*               : registered stage contents and operands
//   bubble_cnt         : number of load-use bubbles inserted
module id_ex_stage
    import rv32_pkg::*;
#(
    parameter int DATA_W = rv32_pkg::XLEN,
    parameter int OP_W   = rv32_pkg::ALU_OP_W,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [DATA_W-1:0]     id_pc,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_rd_wen,
    input  logic [DATA_W-1:0]     id_imm,
    input  logic [OP_W-1:0]       id_alu_op,
    input  logic                  id_is_load,
    input  logic                  id_is_store,
    input  logic                  id_is_branch,
    input  logic [DATA_W-1:0]     rf_data1,
    input  logic [DATA_W-1:0]     rf_data2,
    input  logic                  wb_wr_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  ex_ready,
    input  logic                  flush,
    output logic                  id_stall,
    output logic                  ex_valid,
    output logic [DATA_W-1:0]     ex_pc,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic                  ex_rd_wen,
    output logic [DATA_W-1:0]     ex_imm,
    output logic [OP_W-1:0]       ex_alu_op,
    output logic                  ex_is_load,
    output logic                  ex_is_store,
    output logic                  ex_is_branch,
    output logic [DATA_W-1:0]     ex_op1,
    output logic [DATA_W-1:0]     ex_op2,
    output logic [CNT_W-1:0]      bubble_cnt
);

    logic              load_in_ex;
    logic              hazard;
    logic [DATA_W-1:0] cap_op1;
    logic [DATA_W-1:0] cap_op2;
    logic [DATA_W-1:0] ref_op1;
    logic [DATA_W-1:0] ref_op2;

    assign load_in_ex = ex_valid & ex_is_load & ex_rd_wen & (ex_rd != '0);
    assign hazard     = id_valid & load_in_ex &
                        ((id_use_rs1 & (id_rs1 == ex_rd)) |
                         (id_use_rs2 & (id_rs2 == ex_rd)));

    // Gated by rst_n so decode is not frozen while the core sits in reset.
    assign id_stall = rst_n & ~flush & (hazard | ~ex_ready);

    id_ex_bypass #(.DATA_W(DATA_W)) u_cap_op1 (
        .rd_idx(id_rs1), .wr_en(wb_wr_en), .wr_idx(wb_rd), .wr_data(wb_data),
        .base_data(rf_data1), .data(cap_op1)
    );

    id_ex_bypass #(.DATA_W(DATA_W)) u_cap_op2 (
        .rd_idx(id_rs2), .wr_en(wb_wr_en), .wr_idx(wb_rd), .wr_data(wb_data),
        .base_data(rf_data2), .data(cap_op2)
    );

    // Refresh reuses the held operand as its base value. For ex_rs == x0 the
    // mux returns 0, which the held operand already is.
    id_ex_bypass #(.DATA_W(DATA_W)) u_ref_op1 (
        .rd_idx(ex_rs1), .wr_en(wb_wr_en), .wr_idx(wb_rd), .wr_data(wb_data),
        .base_data(ex_op1), .data(ref_op1)
    );

    id_ex_bypass #(.DATA_W(DATA_W)) u_ref_op2 (
        .rd_idx(ex_rs2), .wr_en(wb_wr_en), .wr_idx(wb_rd), .wr_data(wb_data),
        .base_data(ex_op2), .data(ref_op2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_rd_wen    <= 1'b0;
            ex_imm       <= '0;
            ex_alu_op    <= '0;
            ex_is_load   <= 1'b0;
            ex_is_store  <= 1'b0;
            ex_is_branch <= 1'b0;
            ex_op1       <= '0;
            ex_op2       <= '0;
            bubble_cnt   <= '0;
        end else if (flush) begin
            ex_valid     <= 1'b0;
            ex_rd_wen    <= 1'b0;
            ex_is_load   <= 1'b0;
            ex_is_store  <= 1'b0;
            ex_is_branch <= 1'b0;
        end else if (!ex_ready) begin
            if (ex_valid) begin
                ex_op1 <= ref_op1;
                ex_op2 <= ref_op2;
            end
        end else if (hazard) begin
            ex_valid     <= 1'b0;
            ex_rd_wen    <= 1'b0;
            ex_is_load   <= 1'b0;
            ex_is_store  <= 1'b0;
            ex_is_branch <= 1'b0;
            if (bubble_cnt != '1) begin
                bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            ex_valid     <= id_valid;
            ex_pc        <= id_pc;
            ex_rs1       <= id_rs1;
            ex_rs2       <= id_rs2;
            ex_rd        <= id_rd;
            ex_rd_wen    <= id_rd_wen;
            ex_imm       <= id_imm;
            ex_alu_op    <= id_alu_op;
            ex_is_load   <= id_is_load;
            ex_is_store  <= id_is_store;
            ex_is_branch <= id_is_branch;
            ex_op1       <= cap_op1;
            ex_op2       <= cap_op2;
        end
    end

endmodule
